// File: rtl/fetch_prefetch.sv
// Fetch stage with a DEPTH-entry prefetch queue between instruction memory and decode.
// Optional saturating performance counters are built when FETCH_PERF_EN is defined.
module fetch_prefetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4,
  parameter int PC_INC = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(16'h0800)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_stall,
  input  logic              halt,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_err,
  output logic              if_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_next,
  output logic              fetch_stall,
  output logic              err,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_stalls
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  typedef enum logic [1:0] {IDLE, REQ, DROP, HALTED} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    count_after;
  logic              halted;
  logic              halt_eff;
  logic              push;
  logic              pop;

  assign if_valid    = (count != '0);
  assign instr       = if_valid ? q_data[rd_ptr] : NOP_INSTR;
  assign if_pc       = if_valid ? q_pc[rd_ptr] : '0;
  assign if_pc_next  = if_pc + INC;
  assign fetch_stall = ~if_valid & ~halted & ~err;
  assign pop         = if_valid & ~id_stall;
  assign halt_eff    = halt | halted;
  assign push        = (state == REQ) & mem_done & ~mem_err & ~redirect;

  // Occupancy after this edge; a redirect flushes regardless of push/pop.
  always_comb begin
    count_after = count;
    if (redirect)
      count_after = '0;
    else
      count_after = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= mem_data;
      q_pc[wr_ptr]   <= mem_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_rd   <= 1'b0;
      mem_addr <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      halted   <= 1'b0;
      err      <= 1'b0;
    end else begin
      halted <= halted | halt;
      count  <= count_after;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (redirect)
        fetch_pc <= redirect_pc;
      else if (push)
        fetch_pc <= fetch_pc + INC;

      case (state)
        IDLE: begin
          if (halt_eff || err) begin
            state <= HALTED;
          end else if (redirect) begin
            mem_rd   <= 1'b1;
            mem_addr <= redirect_pc;
            state    <= REQ;
          end else if (count < FULL) begin
            mem_rd   <= 1'b1;
            mem_addr <= fetch_pc;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_done) begin
            if (mem_err) begin
              err    <= 1'b1;
              mem_rd <= 1'b0;
              state  <= HALTED;
            end else if (redirect) begin
              // Wrong-path data is dropped and the target is requested at once.
              if (halt_eff) begin
                mem_rd <= 1'b0;
                state  <= HALTED;
              end else begin
                mem_addr <= redirect_pc;
              end
            end else if (!halt_eff && (count_after < FULL)) begin
              mem_addr <= mem_addr + INC;
            end else begin
              mem_rd <= 1'b0;
              state  <= halt_eff ? HALTED : IDLE;
            end
          end else if (redirect) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (mem_done) begin
            mem_rd <= 1'b0;
            if (mem_err) begin
              err   <= 1'b1;
              state <= HALTED;
            end else begin
              state <= halt_eff ? HALTED : IDLE;
            end
          end
        end
        HALTED: begin
          mem_rd <= 1'b0;
        end
        default: begin
          mem_rd <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
    end else begin
      if (pop && (perf_fetched != 16'hFFFF))
        perf_fetched <= perf_fetched + 16'd1;
      if (fetch_stall && (perf_stalls != 16'hFFFF))
        perf_stalls <= perf_stalls + 16'd1;
    end
  end
`else
  assign perf_fetched = 16'd0;
  assign perf_stalls  = 16'd0;
`endif

endmodule
